pc_fetch_ctrl: RTL and testbench

PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

---
 rtl/pc_fetch_ctrl.sv | 170 +++++++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, issues one outstanding imem request at a time and
// presents fetched instructions to decode. Optional build macro: PC_ALIGN_CHECK_EN.
module pc_fetch_ctrl #(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic [WIDTH-1:0] instr_out,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             if_valid
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic             misalign
`endif
);

  typedef enum logic [1:0] {StIdle, StFetch, StWait, StHold} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             kill_q, kill_d;
  logic [WIDTH-1:0] instr_q, instr_d;
  logic [WIDTH-1:0] pc_out_q, pc_out_d;
  logic [WIDTH-1:0] pc4_q, pc4_d;
  logic             valid_q, valid_d;

  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] branch_pc;
  logic             consumed;

  // Wraps modulo 2^WIDTH by construction.
  assign pc_inc = pc_q + {{(WIDTH-3){1'b0}}, 3'd4};

`ifdef PC_ALIGN_CHECK_EN
  logic misalign_q, misalign_d;

  assign branch_pc  = {branch_target[WIDTH-1:2], 2'b00};
  assign misalign_d = branch_taken && (state_q != StIdle) && (branch_target[1:0] != 2'b00);
  assign misalign   = misalign_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end
`else
  assign branch_pc = branch_target;
`endif

  // Decode has taken the current instruction this cycle.
  assign consumed = valid_q && !stall;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    kill_d   = kill_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    pc4_d    = pc4_q;
    valid_d  = consumed ? 1'b0 : valid_q;

    unique case (state_q)
      StIdle: begin
        state_d = StFetch;
      end

      StFetch: begin
        if (branch_taken) begin
          pc_d    = branch_pc;
          valid_d = 1'b0;
          if (imem_gnt) begin
            // Request already accepted for the stale address; drop its response.
            kill_d  = 1'b1;
            state_d = StWait;
          end
        end else if (imem_gnt) begin
          state_d = StWait;
        end
      end

      StWait: begin
        if (branch_taken) begin
          pc_d    = branch_pc;
          valid_d = 1'b0;
          if (imem_rvalid) begin
            kill_d  = 1'b0;
            state_d = StFetch;
          end else begin
            kill_d = 1'b1;
          end
        end else if (imem_rvalid) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = StFetch;
          end else begin
            instr_d  = imem_rdata;
            pc_out_d = pc_q;
            pc4_d    = pc_inc;
            valid_d  = 1'b1;
            pc_d     = pc_inc;
            state_d  = stall ? StHold : StFetch;
          end
        end
      end

      StHold: begin
        if (branch_taken) begin
          pc_d    = branch_pc;
          valid_d = 1'b0;
          state_d = StFetch;
        end else if (!stall) begin
          state_d = StFetch;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      pc_q     <= RESET_VECTOR;
      kill_q   <= 1'b0;
      instr_q  <= '0;
      pc_out_q <= '0;
      pc4_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      kill_q   <= kill_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      pc4_q    <= pc4_d;
      valid_q  <= valid_d;
    end
  end

  assign imem_req  = (state_q == StFetch);
  assign imem_addr = pc_q;
  assign instr_out = instr_q;
  assign pc_out    = pc_out_q;
  assign pc_plus4  = pc4_q;
  assign if_valid  = valid_q;

`ifndef SYNTHESIS
  // An un-granted request must persist with a stable address unless redirected.
  a_req_stable: assert property (@(posedge clk) disable iff (rst)
    imem_req && !imem_gnt && !branch_taken |=> imem_req && $stable(imem_addr));

  a_kill_in_wait: assert property (@(posedge clk) disable iff (rst)
    kill_q |-> state_q == StWait);
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Randomized bench for pc_fetch_ctrl, checked every cycle against a transaction-level model.
module tb_pc_fetch_ctrl;

  localparam int unsigned W  = 32;
  localparam logic [31:0] RV = 32'h100;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          stall = 1'b0;
  logic          branch_taken = 1'b0;
  logic [W-1:0]  branch_target = '0;
  logic          imem_req;
  logic [W-1:0]  imem_addr;
  logic          imem_gnt = 1'b0;
  logic          imem_rvalid = 1'b0;
  logic [W-1:0]  imem_rdata = '0;
  logic [W-1:0]  instr_out;
  logic [W-1:0]  pc_out;
  logic [W-1:0]  pc_plus4;
  logic          if_valid;
`ifdef PC_ALIGN_CHECK_EN
  logic          misalign;
`endif

  pc_fetch_ctrl #(
    .WIDTH       (W),
    .RESET_VECTOR(RV)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .instr_out    (instr_out),
    .pc_out       (pc_out),
    .pc_plus4     (pc_plus4),
    .if_valid     (if_valid)
`ifdef PC_ALIGN_CHECK_EN
    ,
    .misalign     (misalign)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Transaction-level model: is the fetcher started, is a request in flight, is its response
  // to be dropped, is decode holding the current instruction.
  bit          m_started, m_busy, m_drop, m_hold, m_valid, m_mis;
  logic [31:0] m_pc, m_instr, m_pcout, m_pc4;

  task automatic model_reset();
    m_started = 0; m_busy = 0; m_drop = 0; m_hold = 0; m_valid = 0; m_mis = 0;
    m_pc = RV; m_instr = '0; m_pcout = '0; m_pc4 = '0;
  endtask

  function automatic bit model_req();
    return m_started && !m_busy && !m_hold;
  endfunction

  task automatic model_step(input bit r, input bit st, input bit br, input logic [31:0] tgt,
                            input bit g, input bit rv, input logic [31:0] rd);
    bit          consumed;
    logic [31:0] dest;
    if (r) begin
      model_reset();
      return;
    end
    m_mis = 0;
    if (!m_started) begin
      m_started = 1;
      return;
    end
    dest = tgt;
`ifdef PC_ALIGN_CHECK_EN
    m_mis = br && (tgt[1:0] != 2'b00);
    dest[1:0] = 2'b00;
`endif
    consumed = m_valid && !st;
    if (br) begin
      m_pc = dest;
      m_valid = 0;
      if (m_busy) begin
        if (rv) begin m_busy = 0; m_drop = 0; end
        else m_drop = 1;
      end else if (m_hold) begin
        m_hold = 0;
      end else if (g) begin
        m_busy = 1; m_drop = 1;
      end
    end else if (m_busy) begin
      if (rv && m_drop) begin
        m_busy = 0; m_drop = 0;
        if (consumed) m_valid = 0;
      end else if (rv) begin
        m_busy = 0;
        m_instr = rd; m_pcout = m_pc; m_pc4 = m_pc + 32'd4; m_pc = m_pc + 32'd4;
        m_valid = 1; m_hold = st;
      end else if (consumed) begin
        m_valid = 0;
      end
    end else if (m_hold) begin
      if (!st) begin m_hold = 0; m_valid = 0; end
    end else begin
      if (g) m_busy = 1;
      if (consumed) m_valid = 0;
    end
  endtask

  task automatic check_outputs();
    bit exp_req;
    exp_req = model_req();
    check_eq("imem_req", 32'(imem_req), 32'(exp_req));
    if (exp_req || !m_started) check_eq("imem_addr", imem_addr, m_pc);
    check_eq("if_valid", 32'(if_valid), 32'(m_valid));
    check_eq("instr_out", instr_out, m_instr);
    check_eq("pc_out", pc_out, m_pcout);
    check_eq("pc_plus4", pc_plus4, m_pc4);
`ifdef PC_ALIGN_CHECK_EN
    check_eq("misalign", 32'(misalign), 32'(m_mis));
`endif
  endtask

  function automatic logic [31:0] pick_target();
    logic [31:0] t;
    case ($urandom_range(5))
      0: t = 32'h0000_2000;
      1: t = 32'hFFFF_FFFC;
      2: t = 32'h0000_2002;
      3: t = $urandom & 32'hFFFF_FFFC;
      default: t = $urandom;
    endcase
    return t;
  endfunction

  int pend = -1;  // cycles until the in-flight response's rvalid, -1 when none

  task automatic drive_cycle(input int gnt_pct, input int stall_pct, input int br_pct,
                             input int rst_pct, input int max_dly);
    @(negedge clk);
    check_outputs();
    rst           = ($urandom_range(99) < rst_pct);
    stall         = ($urandom_range(99) < stall_pct);
    branch_taken  = ($urandom_range(99) < br_pct);
    branch_target = pick_target();
    imem_gnt      = ($urandom_range(99) < gnt_pct);
    imem_rdata    = $urandom;
    imem_rvalid   = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        imem_rvalid = 1'b1;
        pend = -1;
      end
    end else if (!m_started) begin
      imem_rvalid = $urandom_range(1) == 1;  // stray response while idle must be ignored
    end
    if (rst) pend = -1;
    else if (model_req() && imem_gnt) pend = $urandom_range(max_dly, 1);
    model_step(rst, stall, branch_taken, branch_target, imem_gnt, imem_rvalid, imem_rdata);
  endtask

  initial begin
    model_reset();
    repeat (2) drive_cycle(0, 0, 0, 100, 1);
    repeat (12) drive_cycle(100, 0, 0, 0, 1);     // ideal memory: 'h100, 'h104, 'h108 ...
    repeat (40) drive_cycle(100, 70, 0, 0, 1);    // heavy stall
    repeat (80) drive_cycle(70, 30, 15, 0, 3);    // redirects incl. wrap and misaligned targets
    repeat (3000) drive_cycle(60, 30, 10, 1, 3);  // everything, including mid-flight resets
    @(negedge clk);
    check_outputs();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
